// File: rtl/mux_rr_stream.sv
// N-to-1 stream mux (fixed select or round-robin) that holds a channel until its packet ends.
// Latency: 1 cycle from input transfer to registered output; sustains 1 beat per cycle.
// Backpressure: in_ready only to the granted channel, and only when the output register is empty or draining.
module mux_rr_stream #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           Clk,
    input  logic           Reset_L,
    input  logic [N*W-1:0] in,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out,
    output logic           out_last,
    output logic [SW-1:0]  out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  out_q, out_d;
    logic          out_last_q, out_last_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic          out_valid_q, out_valid_d;

    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] scan_idx;
    int            rr_idx;

    logic [W-1:0]  grant_dat;
    logic          grant_in_vld;
    logic          grant_in_last;
    logic          can_load;
    logic          xfer;

    // Output register may take a new beat when empty or being drained this cycle.
    assign can_load = ~out_valid_q | out_ready;

    // Grant selection: lock channel wins; otherwise fixed select or round-robin scan from ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        scan_idx  = '0;
        if (state_q == LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = lock_ch_q;
        end else if (!mode) begin
            // Out-of-range select grants nobody.
            if (int'(sel) < N) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end else begin
            // Walk farthest-first so the closest valid channel to ptr is the one left standing.
            for (int k = N - 1; k >= 0; k--) begin
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= N) begin
                    rr_idx = rr_idx - N;
                end
                scan_idx = SW'(rr_idx);
                if (in_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    // Steer the granted channel's data/flags and raise its single ready bit.
    always_comb begin
        grant_dat     = '0;
        grant_in_vld  = 1'b0;
        grant_in_last = 1'b0;
        in_ready      = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_dat     = in[i*W +: W];
                grant_in_vld  = in_valid[i];
                grant_in_last = in_last[i];
                // Ready is forced low while reset is held.
                in_ready[i]   = Reset_L & can_load & grant_vld;
            end
        end
    end

    assign xfer = grant_vld & can_load & grant_in_vld;

    // Next-state for the output register, packet lock FSM and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        ptr_d       = ptr_q;
        out_d       = out_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;

        if (xfer) begin
            out_d       = grant_dat;
            out_last_d  = grant_in_last;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            // Drained with no replacement: payload fields keep their last values.
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (xfer && !grant_in_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant_idx;
                end
            end
            LOCKED: begin
                if (xfer && grant_in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pointer advances only when a round-robin packet completes.
        if (xfer && grant_in_last && mode) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // State registers; reset drops any held beat and lock immediately.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            ptr_q       <= '0;
            out_q       <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream (N=4, W=8): directed vectors with literal expectations
// plus a packet-level reference model compared every cycle.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_mux_rr_stream;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           Clk = 1'b0;
    logic           Reset_L = 1'b0;
    logic [N*W-1:0] in;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out;
    logic           out_last;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    mux_rr_stream #(.N(N), .W(W), .SW(SW)) dut (
        .Clk       (Clk),
        .Reset_L   (Reset_L),
        .in        (in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out       (out),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_vld    = 1'b0;
    logic [7:0]  m_dat    = '0;
    bit          m_last   = 1'b0;
    int          m_sel    = 0;
    bit          m_locked = 1'b0;
    int          m_lock   = 0;
    int          m_ptr    = 0;
    bit          rst_seen = 1'b0;

    // Channel the rules say is granted this cycle, or -1 for none.
    function automatic int model_grant();
        int c;
        if (m_locked) return m_lock;
        if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge Reset_L) rst_seen = 1'b1;

    logic [N-1:0] exp_rdy;
    int           mg;
    bit           mlast;

    initial begin
        forever begin
            @(negedge Clk);
            #1;
            mg      = model_grant();
            exp_rdy = '0;
            if (Reset_L && (!m_vld || out_ready) && mg >= 0) exp_rdy[mg] = 1'b1;
            check("model_out_valid", out_valid, m_vld);
            check("model_out",       out,       m_dat);
            check("model_out_last",  out_last,  m_last);
            check("model_out_sel",   out_sel,   m_sel);
            check("model_in_ready",  in_ready,  exp_rdy);
            @(posedge Clk);
            if (rst_seen || !Reset_L) begin
                m_vld = 0; m_dat = 0; m_last = 0; m_sel = 0;
                m_locked = 0; m_lock = 0; m_ptr = 0;
                rst_seen = 0;
            end
            if (Reset_L) begin
                mg = model_grant();
                if (mg >= 0 && (!m_vld || out_ready) && in_valid[mg]) begin
                    mlast  = in_last[mg];
                    m_dat  = in[mg*W +: W];
                    m_last = mlast;
                    m_sel  = mg;
                    m_vld  = 1'b1;
                    if (!m_locked && !mlast) begin
                        m_locked = 1'b1;
                        m_lock   = mg;
                    end else if (m_locked && mlast) begin
                        m_locked = 1'b0;
                    end
                    if (mlast && mode) m_ptr = (mg + 1) % N;
                end else if (out_ready) begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int exp_fix [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int exp_rr  [6] = '{0, 1, 2, 3, 0, 1};
    int exp_ss  [4] = '{2, 0, 2, 0};
    int exp_sr  [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    initial begin
        in = '0; in_valid = '0; in_last = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;

        // Reset state
        @(negedge Clk); #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out",       out,       0);
        check("rst_out_last",  out_last,  0);
        check("rst_out_sel",   out_sel,   0);
        check("rst_in_ready",  in_ready,  0);

        // Fixed select sweep
        @(negedge Clk);
        Reset_L = 1'b1;
        in = 32'h44_33_22_11; in_valid = 4'hF; in_last = 4'hF; mode = 1'b0;
        for (int s = 0; s <= 4; s++) begin
            if (s > 0) @(negedge Clk);
            if (s < 4) sel = SW'(s);
            #2;
            if (s < 4) check("fix_in_ready", in_ready, 32'(1 << s));
            if (s > 0) begin
                check("fix_out",     out,     exp_fix[s-1]);
                check("fix_out_sel", out_sel, s - 1);
            end
        end

        // Round-robin fairness with wrap (ptr starts at 0)
        for (int k = 0; k < 7; k++) begin
            @(negedge Clk);
            if (k == 0) mode = 1'b1;
            #2;
            if (k > 0) check("rr_out_sel", out_sel, exp_rr[k-1]);
            if (k == 6) in_valid = 4'h0;
        end

        // Sparse round-robin: move ptr to 1 with a single beat on channel 0
        @(negedge Clk);
        in_valid = 4'b0001;
        @(negedge Clk);
        in_valid = 4'b0101;
        #2;
        check("sparse_setup_sel", out_sel, 0);
        check("sparse_first_rdy", in_ready, 4'b0100);
        for (int j = 0; j < 4; j++) begin
            @(negedge Clk); #2;
            check("sparse_out_sel",  out_sel,  exp_ss[j]);
            check("sparse_in_ready", in_ready, exp_sr[j]);
            if (j == 3) in_valid = 4'h0;
        end

        // Packet lock on channel 1 (ptr=1) with a 2-cycle valid gap, channel 2 waiting
        @(negedge Clk);
        in = 32'h44_33_A1_11; in_valid = 4'b0110; in_last = 4'b0000;
        #2;
        check("lock_first_rdy", in_ready, 4'b0010);
        @(negedge Clk);
        in_valid = 4'b0100;
        #2;
        check("lock_b1_out", out, 8'hA1);
        check("lock_b1_sel", out_sel, 1);
        check("lock_gap_rdy", in_ready, 4'b0010);
        @(negedge Clk); #2;
        check("lock_gap2_rdy", in_ready, 4'b0010);
        check("lock_gap_bubble", out_valid, 0);
        @(negedge Clk);
        in_valid = 4'b0110; in[15:8] = 8'hA2;
        #2;
        check("lock_b2_rdy", in_ready, 4'b0010);
        @(negedge Clk);
        in[15:8] = 8'hA3; in_last = 4'b0010;
        #2;
        check("lock_b2_out", out, 8'hA2);
        check("lock_b2_sel", out_sel, 1);
        @(negedge Clk);
        in_valid = 4'b0100; in_last = 4'b0100;
        #2;
        check("lock_b3_out",  out,      8'hA3);
        check("lock_b3_last", out_last, 1);
        check("lock_b3_sel",  out_sel,  1);
        check("lock_release_rdy", in_ready, 4'b0100);
        @(negedge Clk);
        in_valid = 4'h0;
        #2;
        check("lock_next_sel", out_sel, 2);
        check("lock_next_out", out, 8'h33);

        // Backpressure: hold 5 cycles, then resume without loss or duplication
        @(negedge Clk);
        mode = 1'b0; sel = 2'd3; in = 32'h55_33_A3_11; in_valid = 4'b1000; in_last = 4'hF;
        for (int b = 1; b <= 5; b++) begin
            @(negedge Clk);
            if (b == 1) begin
                out_ready = 1'b0;
                in[31:24] = 8'h66;
            end
            #2;
            check("bp_hold_out",   out,       8'h55);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_rdy",   in_ready,  4'b0000);
        end
        @(negedge Clk);
        out_ready = 1'b1;
        #2;
        check("bp_resume_rdy", in_ready, 4'b1000);
        check("bp_resume_out", out, 8'h55);
        @(negedge Clk);
        in_valid = 4'h0;
        #2;
        check("bp_next_out",   out,       8'h66);
        check("bp_next_valid", out_valid, 1);
        @(negedge Clk); #2;
        check("bp_drain_valid", out_valid, 0);
        check("bp_drain_hold",  out,       8'h66);

        // Reset in the middle of a 3-beat packet on channel 3 (ptr=3)
        @(negedge Clk);
        mode = 1'b1; in = 32'hD1_33_A3_11; in_valid = 4'b1001; in_last = 4'b0000;
        #2;
        check("rstp_first_rdy", in_ready, 4'b1000);
        @(negedge Clk);
        in[31:24] = 8'hD2;
        #2;
        check("rstp_b1_out", out, 8'hD1);
        check("rstp_b1_sel", out_sel, 3);
        check("rstp_locked_rdy", in_ready, 4'b1000);
        Reset_L = 1'b0;
        #1;
        check("rstp_async_valid", out_valid, 0);
        check("rstp_async_out",   out,       0);
        check("rstp_async_rdy",   in_ready,  0);
        Reset_L = 1'b1;
        #1;
        check("rstp_after_rdy", in_ready, 4'b0001);
        @(negedge Clk); #2;
        check("rstp_after_sel",   out_sel,   0);
        check("rstp_after_out",   out,       8'h11);
        check("rstp_after_valid", out_valid, 1);
        in_valid = 4'h0;
        repeat (3) @(negedge Clk);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_stream.md
MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, in bits; legal range 1..64.
REQ-003 Parameter SW, default 2: select width, equal to clog2(N); it is a derived constant, not a user setting.
REQ-004 Clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Reset_L  input  1: asynchronous, active-low reset.
REQ-006 in  input  N*W: channel i data occupies bits [i*W+W-1 : i*W].
REQ-007 in_valid  input  N: channel i holds a beat.
REQ-008 in_last  input  N: channel i beat is the final beat of its packet.
REQ-009 in_ready  output  N: channel i beat is accepted this cycle.
REQ-010 mode  input  1: 0 = fixed select; 1 = round-robin arbitration.
REQ-011 sel  input  SW: channel used when mode=0.
REQ-012 out  output  W: registered data.
REQ-013 out_last  output  1: registered last flag.
REQ-014 out_sel  output  SW: channel index of the beat in the output register.
REQ-015 out_valid  output  1: the output register holds a beat.
REQ-016 out_ready  input  1: downstream accepts the beat this cycle.

Function
REQ-017 Transfer on channel i = in_valid[i] & in_ready[i]; output transfer = out_valid & out_ready.
REQ-018 can_load = ~out_valid | out_ready; in_ready[i] = can_load & (grant == i); at most one in_ready bit is high in any cycle.
REQ-019 Grant is combinational from the current state and inputs; in_ready does not depend on in_valid of the granted channel.
REQ-020 Unlocked, mode=0: grant = sel; if sel >= N, no in_ready bit is asserted.
REQ-021 Unlocked, mode=1: grant is the first channel with in_valid set, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1; if no in_valid is set, no grant.
REQ-022 On an input transfer, out, out_last and out_sel load the granted channel's data, last flag and index on the next edge, and out_valid is set: latency is 1 cycle.
REQ-023 If an output transfer occurs with no input transfer, out_valid clears; out, out_last and out_sel hold their values.
REQ-024 When out_valid=1 and out_ready=0, the output register holds; all in_ready bits are 0.
REQ-025 A simultaneous output transfer and input transfer replaces the beat, so back-to-back throughput is 1 beat per cycle.
REQ-026 The packet state machine has two states, IDLE and LOCKED; reset places it in IDLE.
REQ-027 IDLE to LOCKED: on a transfer with in_last=0; the lock channel is captured as the granted index.
REQ-028 LOCKED: grant = lock channel regardless of mode, sel and other channels' valid; a gap in lock-channel valid inserts bubbles and does not release the lock.
REQ-029 LOCKED to IDLE: on a transfer from the lock channel with in_last=1.
REQ-030 A single-beat packet (in_last=1 on the first beat) does not enter LOCKED.
REQ-031 Changes to mode or sel while LOCKED take effect only after return to IDLE.
REQ-032 Round-robin pointer: when a transfer completes a packet (in_last=1) in mode=1, ptr <= (granted index + 1) mod N; the wrap from N-1 goes to 0.
REQ-033 The pointer is unchanged by mode=0 traffic and by non-last beats.
REQ-034 No combinational path exists from in or in_valid to out, out_valid or out_sel.

Reset
REQ-035 While Reset_L=0: out_valid=0, out=0, out_last=0, out_sel=0, ptr=0, state=IDLE, lock channel=0, all in_ready=0.
REQ-036 Reset asserted mid-packet discards the held beat and the lock immediately, without waiting for a clock edge.
REQ-037 After release, the first grant follows REQ-020 or REQ-021 with ptr=0.

Verification (N=4, W=8)
REQ-038 Fixed select: mode=0, out_ready=1; sweep sel 0..3 with in = 0x44_33_22_11 and all valid, last=1 -> out = 0x11, 0x22, 0x33, 0x44 one cycle after each sel, with out_sel matching.
REQ-039 Round-robin fairness: mode=1, all valid, last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,...; after ptr=3, grant wraps to 0.
REQ-040 Packet lock: mode=1; channel 1 sends a 3-beat packet (last on beat 3) while channel 2 is valid; channel 1 valid drops for 2 cycles mid-packet -> in_ready[2] stays 0 and out_sel=1 for all 3 beats; channel 2 is granted in the next cycle.
REQ-041 Backpressure: out_ready held 0 for 5 cycles with out_valid=1 -> out is stable and in_ready=0000; on out_ready=1, the next beat loads in the same cycle with no lost or duplicated beat.
REQ-042 Reset mid-packet: Reset_L pulsed low during beat 2 of a 3-beat packet on channel 3 -> out_valid=0 and state=IDLE at once; after release, channel 0 (valid) is granted first.
REQ-043 Sparse round-robin: only channels 0 and 2 valid, ptr=1 -> grant goes to 2, then to 0; channels 1 and 3 are never granted.
